// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg : shared encodings for the MIPS32 pipeline controller
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  // Reset level seen on the rst port
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  // Bit positions inside the per-stage stall vector
  localparam int STALL_PC    = 0;
  localparam int STALL_IF    = 1;
  localparam int STALL_IFID  = 2;
  localparam int STALL_IDEX  = 3;
  localparam int STALL_EXMEM = 4;
  localparam int STALL_MEMWB = 5;
  localparam int STALL_W     = 6;

  typedef logic [STALL_W-1:0] stall_vec_t;

  localparam stall_vec_t STALL_NONE    = 6'b000000;
  localparam stall_vec_t STALL_LOADUSE = 6'b000111;
  localparam stall_vec_t STALL_MC      = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_RUN  = 2'd1,
    ST_MC_DONE = 2'd2
  } mc_state_e;

  localparam int PERF_W = 32;

  function automatic logic stall_active(input stall_vec_t s);
    return (s != STALL_NONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if : hazard inputs and stall/flush outputs of the pipeline controller
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if;

  logic        id_reg_read1_i;
  logic        id_reg_read2_i;
  logic [4:0]  id_reg_addr1_i;
  logic [4:0]  id_reg_addr2_i;
  logic        ex_is_load_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_mc_start_i;
  logic        flush_req_i;

  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_busy_o;
  logic        mc_done_o;
  logic [31:0] stall_cnt_o;

  // Pipeline side: supplies decode/execute status, consumes controls
  modport master (
    output id_reg_read1_i, id_reg_read2_i, id_reg_addr1_i, id_reg_addr2_i,
    output ex_is_load_i, ex_wreg_i, ex_wd_i, ex_mc_start_i, flush_req_i,
    input  stall_o, flush_o, mc_busy_o, mc_done_o, stall_cnt_o
  );

  modport slave (
    input  id_reg_read1_i, id_reg_read2_i, id_reg_addr1_i, id_reg_addr2_i,
    input  ex_is_load_i, ex_wreg_i, ex_wd_i, ex_mc_start_i, flush_req_i,
    output stall_o, flush_o, mc_busy_o, mc_done_o, stall_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_hazard_detect : load-use compare between one load in EX and ID sources
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_hazard_detect #(
  parameter int ADDR_W = 5
) (
  input  wire logic              i_rd1,
  input  wire logic              i_rd2,
  input  wire logic [ADDR_W-1:0] i_addr1,
  input  wire logic [ADDR_W-1:0] i_addr2,
  input  wire logic              i_is_load,
  input  wire logic              i_wreg,
  input  wire logic [ADDR_W-1:0] i_wd,
  output logic                   o_load_use
);

  logic w_dst_valid;
  logic w_hit1;
  logic w_hit2;

  // $0 is hardwired to zero, so writing it never creates a dependency
  assign w_dst_valid = i_is_load & i_wreg & (i_wd != '0);
  assign w_hit1      = i_rd1 & (i_addr1 == i_wd);
  assign w_hit2      = i_rd2 & (i_addr2 == i_wd);
  assign o_load_use  = w_dst_valid & (w_hit1 | w_hit2);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl : stall/flush arbitration, multi-cycle EX sequencing, stall counter
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(1);
  localparam logic [PERF_W-1:0] C_PERF_MAX = '1;

  mc_state_e         r_state;
  mc_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic       w_load_use;
  logic       w_mc_stall;
  logic       w_flush;
  stall_vec_t w_stall;

  pipe_ctrl_hazard_detect #(
    .ADDR_W (5)
  ) u_hazard_detect (
    .i_rd1      (bus.id_reg_read1_i),
    .i_rd2      (bus.id_reg_read2_i),
    .i_addr1    (bus.id_reg_addr1_i),
    .i_addr2    (bus.id_reg_addr2_i),
    .i_is_load  (bus.ex_is_load_i),
    .i_wreg     (bus.ex_wreg_i),
    .i_wd       (bus.ex_wd_i),
    .o_load_use (w_load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    w_flush     = 1'b0;
    w_stall     = STALL_NONE;

    case (r_state)
      ST_IDLE: begin
        // The start cycle itself already holds the front end
        w_mc_stall = bus.ex_mc_start_i;
        if (bus.ex_mc_start_i && !bus.flush_req_i) begin
          w_state_nxt = ST_MC_RUN;
          w_cnt_nxt   = C_CNT_LOAD;
        end
      end
      ST_MC_RUN: begin
        w_mc_stall = 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_MC_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_LAST;
        end
      end
      ST_MC_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Flush aborts any running op; load-use is masked by the wider MC stall
    if (bus.flush_req_i) begin
      w_flush     = 1'b1;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_mc_stall) begin
      w_stall = STALL_MC;
    end else if (w_load_use) begin
      w_stall = STALL_LOADUSE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_stall_cnt <= '0;
    end else if (stall_active(w_stall) && (r_stall_cnt != C_PERF_MAX)) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign bus.stall_o     = w_stall;
  assign bus.flush_o     = w_flush;
  assign bus.mc_busy_o   = (r_state == ST_MC_RUN);
  assign bus.mc_done_o   = (r_state == ST_MC_DONE);
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS32 flow CPU.
- Detects load-use hazards that ID forwarding from EX/MEM cannot resolve.
- Sequences multi-cycle EX operations (div/mult) with an internal counter FSM.
- Arbitrates stall versus flush requests and drives the per-stage stall vector to the PC and all pipeline registers.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 32, total cycles a multi-cycle EX op holds the pipe (must be >= 2)
CNT_W, 6, width of internal multi-cycle counter (must hold MULDIV_CYCLES-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
id_reg_read1_i  in  1  ID reads source operand 1 from the register file
id_reg_read2_i  in  1  ID reads source operand 2 from the register file
id_reg_addr1_i  in  5  ID source address 1
id_reg_addr2_i  in  5  ID source address 2
ex_is_load_i  in  1  instruction currently in EX is a load
ex_wreg_i  in  1  EX instruction writes a register
ex_wd_i  in  5  EX destination register
ex_mc_start_i  in  1  EX holds a multi-cycle op requesting execution (level)
flush_req_i  in  1  flush request (exception/redirect) from MEM
stall_o  out  6  [0]=PC [1]=IF [2]=IF/ID [3]=ID/EX [4]=EX/MEM [5]=MEM/WB hold
flush_o  out  1  clear all pipeline registers this cycle
mc_busy_o  out  1  multi-cycle unit running
mc_done_o  out  1  one-cycle pulse: multi-cycle result valid in EX
stall_cnt_o  out  32  count of cycles with stall_o != 0, saturating

Behaviour:
- Reset (rst=0, async):
  - FSM enters IDLE; cnt=0; stall_cnt_o=0.
  - mc_busy_o=0, mc_done_o=0, stall_o=0, flush_o=0.
- load_use (combinational): ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & ((id_reg_read1_i & id_reg_addr1_i==ex_wd_i) | (id_reg_read2_i & id_reg_addr2_i==ex_wd_i)).
  - Register $0 never causes a hazard.
- FSM states: IDLE, MC_RUN, MC_DONE.
  - IDLE: if ex_mc_start_i & !flush_req_i, load cnt=MULDIV_CYCLES-1 and go to MC_RUN.
  - MC_RUN: if cnt==1, go to MC_DONE; otherwise decrement cnt.
  - MC_DONE: go to IDLE unconditionally.
  - ex_mc_start_i is ignored in MC_RUN and MC_DONE. EX must drop it on seeing mc_done_o. A start seen in IDLE on the cycle after MC_DONE is a new op.
- Timing: start seen in IDLE at cycle T.
  - Pipe stalled for exactly MULDIV_CYCLES cycles, T..T+MULDIV_CYCLES-1.
  - MC_DONE occurs at T+MULDIV_CYCLES. mc_done_o=1 only in that cycle, with no multi-cycle stall.
- mc_busy_o = (state==MC_RUN), registered state decode.
- stall_o and flush_o are combinational, with priority flush > multi-cycle > load-use:
  - flush_req_i=1: flush_o=1, stall_o=6'b000000. FSM in MC_RUN/MC_DONE returns to IDLE next edge and cnt clears. No mc_done_o follows an aborted op.
  - else if (IDLE & ex_mc_start_i) or MC_RUN: stall_o=6'b001111 (PC..ID/EX held).
  - else if load_use: stall_o=6'b000111 (PC, IF, IF/ID held; bubble into EX).
  - else stall_o=0.
- Flush and start in the same IDLE cycle: flush wins, no op starts.
- stall_cnt_o increments on each edge where stall_o!=0. It holds at 32'hFFFFFFFF with no wrap.
- Load-use during MC_RUN is masked: the multi-cycle stall already covers ID.

Decomposition:
- Shared defines header gets:
  - stall-vector bit indices;
  - stall encodings STALL_NONE, STALL_LOADUSE, STALL_MC;
  - FSM state encodings;
  - macros RstEnable=1'b0 and RstDisable.
- One natural sub-module: hazard_detect, the purely combinational load_use compare. It is reusable if a second load port is added.
- FSM, counter, priority mux and perf counter stay in pipe_ctrl.

Test Plan:
1. ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=5, id_reg_read1_i=1, id_reg_addr1_i=5 -> stall_o=6'b000111 that cycle. Same stimulus with ex_wd_i=0 -> stall_o=0.
2. MULDIV_CYCLES=4, ex_mc_start_i pulsed in IDLE at T -> stall_o=6'b001111 at T..T+3; mc_busy_o=1 at T+1..T+3; mc_done_o=1 only at T+4 with stall_o=0.
3. MC_RUN at cnt=2 with flush_req_i=1 -> flush_o=1, stall_o=0 that cycle; state IDLE next edge; no mc_done_o pulse.
4. ex_mc_start_i=1 and load_use both true in IDLE -> stall_o=6'b001111, not 6'b000111.
5. Assert rst=0 asynchronously mid-MC_RUN -> outputs and stall_cnt_o go to 0 without a clock edge. After release, an IDLE start behaves as in scenario 2.
6. Preload stall_cnt_o near max (force to 32'hFFFFFFFE), hold a load-use stall 3 cycles -> reads 32'hFFFFFFFF and stays there.
